// File: rtl/tmds_word_align.sv
// Word-alignment controller for one HDMI RX TMDS channel: hunts for runs of
// control tokens during blanking and slips the word boundary until they appear.
module tmds_word_align #(
   parameter int WIN_LEN      = 4096,
   parameter int RUN_LEN      = 8,
   parameter int LOCK_HITS    = 4,
   parameter int SLIP_PULSE   = 2,
   parameter int SETTLE_CYC   = 8,
   parameter int LOSS_WINDOWS = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [9:0] data_in,
   output logic       bitslip,
   output logic       locked,
   output logic [3:0] slip_cnt,
   output logic       align_err
);

   localparam int WIN_W  = $clog2(WIN_LEN);
   localparam int PH_MAX = (SLIP_PULSE > SETTLE_CYC) ? SLIP_PULSE : SETTLE_CYC;
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WIN_LEN - 1);
   localparam logic [3:0]       RUN_TOP     = 4'(RUN_LEN);
   localparam logic [3:0]       RUN_PRE     = 4'(RUN_LEN - 1);
   localparam logic [3:0]       LOCK_TOP    = 4'(LOCK_HITS);
   localparam logic [3:0]       LOSS_TOP    = 4'(LOSS_WINDOWS);
   localparam logic [PH_W-1:0]  SLIP_LAST   = PH_W'(SLIP_PULSE - 1);
   localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SLIP   = 2'd1,
      SETTLE = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [9:0]       prev_word;
   logic [3:0]       run_cnt, run_n;
   logic [WIN_W-1:0] win_cnt, win_n;
   logic [3:0]       hit_cnt, hit_n;
   logic [3:0]       miss_cnt, miss_n;
   logic [PH_W-1:0]  ph_cnt, ph_n;
   logic [3:0]       slip_n;
   logic             err_n;

   logic       is_token;
   logic       same_word;
   logic       hit;
   logic       win_exp;
   logic [3:0] run_next;
   logic [3:0] hit_sum;

   // A hit is the single edge where a run of identical tokens reaches RUN_LEN;
   // hit_sum already includes it so lock and loss decisions see it immediately.
   always_comb begin
      is_token  = data_in inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
      same_word = (data_in == prev_word);
      hit       = is_token && same_word && (run_cnt == RUN_PRE);
      win_exp   = (win_cnt == WIN_LAST);

      if (!is_token) begin
         run_next = 4'd0;
      end else if (same_word) begin
         run_next = (run_cnt == RUN_TOP) ? RUN_TOP : run_cnt + 4'd1;
      end else begin
         run_next = 4'd1;
      end

      hit_sum = (hit && (hit_cnt != 4'hF)) ? hit_cnt + 4'd1 : hit_cnt;
   end

   always_comb begin
      state_n = state;
      run_n   = run_cnt;
      win_n   = win_cnt;
      hit_n   = hit_cnt;
      miss_n  = miss_cnt;
      ph_n    = ph_cnt;
      slip_n  = slip_cnt;
      err_n   = 1'b0;

      if (!en) begin
         state_n = SEARCH;
         run_n   = '0;
         win_n   = '0;
         hit_n   = '0;
         miss_n  = '0;
         ph_n    = '0;
      end else begin
         case (state)
            SEARCH: begin
               run_n = run_next;
               win_n = win_cnt + WIN_W'(1);
               hit_n = win_exp ? 4'd0 : hit_sum;
               if (hit && (hit_sum == LOCK_TOP)) begin
                  state_n = LOCKED;
                  miss_n  = '0;
               end else if (win_exp) begin
                  state_n = SLIP;
                  ph_n    = '0;
                  run_n   = '0;
                  win_n   = '0;
                  hit_n   = '0;
                  slip_n  = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
                  err_n   = (slip_cnt == 4'd9);
               end
            end

            SLIP: begin
               if (ph_cnt == SLIP_LAST) begin
                  state_n = SETTLE;
                  ph_n    = '0;
               end else begin
                  ph_n = ph_cnt + PH_W'(1);
               end
            end

            // Words are ignored here while the bitslip stage pipeline refills.
            SETTLE: begin
               if (ph_cnt == SETTLE_LAST) begin
                  state_n = SEARCH;
                  ph_n    = '0;
                  run_n   = '0;
                  win_n   = '0;
                  hit_n   = '0;
               end else begin
                  ph_n = ph_cnt + PH_W'(1);
               end
            end

            LOCKED: begin
               run_n = run_next;
               win_n = win_cnt + WIN_W'(1);
               hit_n = win_exp ? 4'd0 : hit_sum;
               if (win_exp) begin
                  if (hit_sum == 4'd0) begin
                     miss_n = miss_cnt + 4'd1;
                     if ((miss_cnt + 4'd1) == LOSS_TOP) begin
                        state_n = SEARCH;
                        run_n   = '0;
                        win_n   = '0;
                        hit_n   = '0;
                        miss_n  = '0;
                     end
                  end else begin
                     miss_n = '0;
                  end
               end
            end

            default: begin
               state_n = SEARCH;
            end
         endcase
      end
   end

   // bitslip and locked are registered from the next state so they line up
   // with the state register and never glitch.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= SEARCH;
         prev_word <= '0;
         run_cnt   <= '0;
         win_cnt   <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         ph_cnt    <= '0;
         slip_cnt  <= '0;
         bitslip   <= 1'b0;
         locked    <= 1'b0;
         align_err <= 1'b0;
      end else begin
         state     <= state_n;
         prev_word <= data_in;
         run_cnt   <= run_n;
         win_cnt   <= win_n;
         hit_cnt   <= hit_n;
         miss_cnt  <= miss_n;
         ph_cnt    <= ph_n;
         slip_cnt  <= slip_n;
         bitslip   <= (state_n == SLIP);
         locked    <= (state_n == LOCKED);
         align_err <= err_n;
      end
   end

endmodule

// File: tb/tb_tmds_word_align.sv
// Scoreboard bench for tmds_word_align: the stimulus pushes expected output
// events (edges of bitslip/locked, align_err pulses) and a monitor pops them.
module tb_tmds_word_align;

   localparam logic [9:0] TOK  = 10'h354;
   localparam logic [9:0] IDLE = 10'h1F0;

   logic       clk     = 1'b0;
   logic       rstn    = 1'b0;
   logic       en      = 1'b1;
   logic [9:0] data_in = IDLE;
   logic       bitslip;
   logic       locked;
   logic [3:0] slip_cnt;
   logic       align_err;

   int   cyc       = 0;
   int   total     = 0;
   int   bad       = 0;
   int   slip_seen = 0;
   logic bs_q      = 1'b0;
   logic lk_q      = 1'b0;

   typedef enum int {BS_RISE, BS_FALL, LK_RISE, LK_FALL, ERR_PULSE} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       cyc;
      int       slip;
   } ev_t;

   ev_t exp_q[$];

   tmds_word_align #(
      .WIN_LEN     (64),
      .RUN_LEN     (8),
      .LOCK_HITS   (2),
      .SLIP_PULSE  (2),
      .SETTLE_CYC  (8),
      .LOSS_WINDOWS(2)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .data_in  (data_in),
      .bitslip  (bitslip),
      .locked   (locked),
      .slip_cnt (slip_cnt),
      .align_err(align_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] rot(input logic [9:0] w, input int off);
      logic [19:0] t;
      t = {w, w} << off;
      return t[19:10];
   endfunction

   // After this returns, cyc is the cycle on which any reaction to w shows.
   task automatic applyStimulus(input logic [9:0] w, input logic e);
      data_in = w;
      en      = e;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic push_event(input ev_kind_t k, input int s);
      ev_t e;
      e.kind = k;
      e.cyc  = cyc;
      e.slip = s;
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_kind_t k);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("[TB] FAIL event: got %s cyc=%0d slip_cnt=%0d, expected none",
                  k.name(), cyc, slip_cnt);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.cyc != cyc || e.slip != int'(slip_cnt)) begin
            bad++;
            $display("[TB] FAIL event: got %s cyc=%0d slip_cnt=%0d, expected %s cyc=%0d slip_cnt=%0d",
                     k.name(), cyc, slip_cnt, e.kind.name(), e.cyc, e.slip);
         end
      end
   endtask

   task automatic drain_check(input string name);
      @(negedge clk);
      #1;
      checkOutput(name, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      en      = 1'b1;
      data_in = IDLE;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      if (bitslip && !bs_q) begin
         observe(BS_RISE);
         slip_seen <= slip_seen + 1;
      end
      if (!bitslip && bs_q) observe(BS_FALL);
      if (locked && !lk_q) observe(LK_RISE);
      if (!locked && lk_q) observe(LK_FALL);
      if (align_err) observe(ERR_PULSE);
      bs_q <= bitslip;
      lk_q <= locked;
   end

   initial begin
      logic [9:0] w;
      int n;
      int slip_mark;

      do_reset();
      checkOutput("reset bitslip", int'(bitslip), 0);
      checkOutput("reset locked", int'(locked), 0);
      checkOutput("reset slip_cnt", int'(slip_cnt), 0);
      checkOutput("reset align_err", int'(align_err), 0);

      $display("[TB] aligned stream, loss and relock");
      for (int i = 1; i <= 364; i++) begin
         if (i <= 160)      w = (((i - 1) % 32) < 12) ? TOK : IDLE;
         else if (i <= 320) w = IDLE;
         else               w = (((i - 321) % 32) < 12) ? TOK : IDLE;
         applyStimulus(w, 1'b1);
         if (i == 40)  push_event(LK_RISE, 0);
         if (i == 320) push_event(LK_FALL, 0);
         if (i == 360) push_event(LK_RISE, 0);
      end
      checkOutput("aligned slip_cnt", int'(slip_cnt), 0);
      applyStimulus(TOK, 1'b0);
      push_event(LK_FALL, 0);
      applyStimulus(TOK, 1'b0);
      drain_check("aligned events drained");
      checkOutput("en low locked", int'(locked), 0);

      $display("[TB] no tokens: slips and align_err");
      do_reset();
      for (int i = 1; i <= 1472; i++) begin
         applyStimulus(IDLE, 1'b1);
         if (i >= 64 && ((i - 64) % 74) == 0) begin
            n = (i - 64) / 74 + 1;
            push_event(BS_RISE, n % 10);
            if ((n % 10) == 0) push_event(ERR_PULSE, 0);
         end
         if (i >= 66 && ((i - 66) % 74) == 0) begin
            n = (i - 66) / 74 + 1;
            push_event(BS_FALL, n % 10);
         end
         if (i == 64) checkOutput("first slip slip_cnt", int'(slip_cnt), 1);
      end
      checkOutput("20 slips slip_cnt", int'(slip_cnt), 0);
      drain_check("no-token events drained");

      $display("[TB] offset stream needing 7 slips");
      do_reset();
      slip_mark = slip_seen;
      for (int i = 1; i <= 548; i++) begin
         w = (((i - 1) % 20) < 12) ? TOK : IDLE;
         applyStimulus(rot(w, (3 + slip_seen - slip_mark) % 10), 1'b1);
         if (i <= 508 && ((i - 64) % 74) == 0 && i >= 64) push_event(BS_RISE, (i - 64) / 74 + 1);
         if (i <= 510 && ((i - 66) % 74) == 0 && i >= 66) push_event(BS_FALL, (i - 66) / 74 + 1);
         if (i == 548) push_event(LK_RISE, 7);
      end
      checkOutput("7-slip slip_cnt", int'(slip_cnt), 7);
      applyStimulus(TOK, 1'b0);
      push_event(LK_FALL, 7);
      applyStimulus(TOK, 1'b0);
      applyStimulus(TOK, 1'b0);
      drain_check("7-slip events drained");
      checkOutput("en low slip_cnt held", int'(slip_cnt), 7);
      checkOutput("en low bitslip", int'(bitslip), 0);

      $display("[TB] reset during slip pulse");
      do_reset();
      for (int i = 1; i <= 64; i++) applyStimulus(IDLE, 1'b1);
      checkOutput("slip pulse high", int'(bitslip), 1);
      checkOutput("slip pulse slip_cnt", int'(slip_cnt), 1);
      rstn = 1'b0;
      #1;
      checkOutput("async reset bitslip", int'(bitslip), 0);
      checkOutput("async reset slip_cnt", int'(slip_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 1; i <= 10; i++) applyStimulus(IDLE, 1'b1);
      checkOutput("post reset bitslip", int'(bitslip), 0);
      checkOutput("post reset locked", int'(locked), 0);
      checkOutput("post reset slip_cnt", int'(slip_cnt), 0);
      checkOutput("post reset align_err", int'(align_err), 0);
      drain_check("reset events drained");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
